// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - ASCII command parser feeding time/date/control updates to the clock core
// Replies K/E through a held valid/ready byte; value outputs change only on an accepted command.
module uart_cmd_parser (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        set_time,
  output logic [7:0]  hours_bcd,
  output logic [7:0]  minutes_bcd,
  output logic [7:0]  seconds_bcd,
  output logic        set_date,
  output logic [15:0] day,
  output logic [15:0] month,
  output logic [15:0] year,
  output logic        pause_toggle,
  output logic        speed_toggle
);

  localparam logic [7:0] CR_CHAR     = 8'h0D;
  localparam logic [7:0] IGNORE_CHAR = 8'h0A;
  localparam logic [7:0] CH_T = 8'h54;
  localparam logic [7:0] CH_D = 8'h44;
  localparam logic [7:0] CH_P = 8'h50;
  localparam logic [7:0] CH_F = 8'h46;
  localparam logic [7:0] ACK_OK  = 8'h4B;
  localparam logic [7:0] ACK_ERR = 8'h45;

  typedef enum logic [2:0] {IDLE, DIGITS, WAIT_CR, DISCARD, RESP} state_t;
  typedef enum logic [1:0] {CMD_T, CMD_D, CMD_P, CMD_F} cmd_t;

  state_t      state, state_next;
  cmd_t        cmd, cmd_next;
  logic [3:0]  cnt;
  logic [23:0] time_sr;
  logic [15:0] day_acc, month_acc, year_acc;
  logic        start_cmd, push, respond, resp_ok;
  logic        is_digit, time_ok, date_ok, cmd_valid;
  logic [3:0]  last_idx;

  function automatic logic [15:0] mac10(input logic [15:0] acc, input logic [3:0] d);
    return (acc << 3) + (acc << 1) + {12'd0, d};
  endfunction

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign last_idx = (cmd == CMD_D) ? 4'd7 : 4'd5;
  // Packed BCD preserves numeric ordering, so the limits compare directly as BCD.
  assign time_ok  = (time_sr[23:16] <= 8'h23) && (time_sr[15:8] <= 8'h59) && (time_sr[7:0] <= 8'h59);
  assign date_ok  = (day_acc >= 16'd1) && (day_acc <= 16'd31) &&
                    (month_acc >= 16'd1) && (month_acc <= 16'd12);

  always_comb begin
    cmd_valid = 1'b1;
    case (cmd)
      CMD_T:   cmd_valid = time_ok;
      CMD_D:   cmd_valid = date_ok;
      default: cmd_valid = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    cmd_next   = cmd;
    start_cmd  = 1'b0;
    push       = 1'b0;
    respond    = 1'b0;
    resp_ok    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && rx_data != CR_CHAR && rx_data != IGNORE_CHAR) begin
          start_cmd = 1'b1;
          case (rx_data)
            CH_T: begin cmd_next = CMD_T; state_next = DIGITS;  end
            CH_D: begin cmd_next = CMD_D; state_next = DIGITS;  end
            CH_P: begin cmd_next = CMD_P; state_next = WAIT_CR; end
            CH_F: begin cmd_next = CMD_F; state_next = WAIT_CR; end
            default: begin start_cmd = 1'b0; state_next = DISCARD; end
          endcase
        end
      end
      DIGITS: begin
        if (rx_valid) begin
          if (is_digit) begin
            push = 1'b1;
            if (cnt == last_idx) state_next = WAIT_CR;
          end else if (rx_data == CR_CHAR) begin
            respond    = 1'b1;
            state_next = RESP;
          end else begin
            state_next = DISCARD;
          end
        end
      end
      WAIT_CR: begin
        if (rx_valid) begin
          if (rx_data == CR_CHAR) begin
            respond    = 1'b1;
            resp_ok    = cmd_valid;
            state_next = RESP;
          end else begin
            state_next = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (rx_valid && rx_data == CR_CHAR) begin
          respond    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (tx_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cmd          <= CMD_T;
      cnt          <= 4'd0;
      time_sr      <= 24'd0;
      day_acc      <= 16'd0;
      month_acc    <= 16'd0;
      year_acc     <= 16'd0;
      tx_data      <= 8'h00;
      tx_valid     <= 1'b0;
      set_time     <= 1'b0;
      set_date     <= 1'b0;
      pause_toggle <= 1'b0;
      speed_toggle <= 1'b0;
      hours_bcd    <= 8'h00;
      minutes_bcd  <= 8'h00;
      seconds_bcd  <= 8'h00;
      day          <= 16'd0;
      month        <= 16'd0;
      year         <= 16'd0;
    end else begin
      state        <= state_next;
      set_time     <= 1'b0;
      set_date     <= 1'b0;
      pause_toggle <= 1'b0;
      speed_toggle <= 1'b0;
      if (start_cmd) begin
        cmd       <= cmd_next;
        cnt       <= 4'd0;
        time_sr   <= 24'd0;
        day_acc   <= 16'd0;
        month_acc <= 16'd0;
        year_acc  <= 16'd0;
      end
      if (push) begin
        cnt <= cnt + 4'd1;
        if (cmd == CMD_T)     time_sr   <= {time_sr[19:0], rx_data[3:0]};
        else if (cnt < 4'd2)  day_acc   <= mac10(day_acc, rx_data[3:0]);
        else if (cnt < 4'd4)  month_acc <= mac10(month_acc, rx_data[3:0]);
        else                  year_acc  <= mac10(year_acc, rx_data[3:0]);
      end
      if (respond) begin
        tx_valid <= 1'b1;
        tx_data  <= resp_ok ? ACK_OK : ACK_ERR;
        if (resp_ok) begin
          case (cmd)
            CMD_T: begin
              set_time    <= 1'b1;
              hours_bcd   <= time_sr[23:16];
              minutes_bcd <= time_sr[15:8];
              seconds_bcd <= time_sr[7:0];
            end
            CMD_D: begin
              set_date <= 1'b1;
              day      <= day_acc;
              month    <= month_acc;
              year     <= year_acc;
            end
            CMD_P:   pause_toggle <= 1'b1;
            default: speed_toggle <= 1'b1;
          endcase
        end
      end
      if (state == RESP && tx_ready) tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - table-driven and directed-sequence bench for uart_cmd_parser
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        set_time, set_date, pause_toggle, speed_toggle;
  logic [7:0]  hours_bcd, minutes_bcd, seconds_bcd;
  logic [15:0] day, month, year;

  int checks = 0;
  int fails  = 0;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] K  = 8'h4B;
  localparam logic [7:0] E  = 8'h45;

  always #5 clk = ~clk;

  uart_cmd_parser dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .set_time(set_time), .hours_bcd(hours_bcd), .minutes_bcd(minutes_bcd),
    .seconds_bcd(seconds_bcd), .set_date(set_date), .day(day), .month(month),
    .year(year), .pause_toggle(pause_toggle), .speed_toggle(speed_toggle)
  );

  typedef struct {
    string       cmd;
    logic [7:0]  resp;
    logic [3:0]  strb;   // {set_time, set_date, pause_toggle, speed_toggle}
    logic [7:0]  hh, mm, ss;
    logic [15:0] dd, mo, yy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input string c, input logic [7:0] r, input logic [3:0] s,
                              input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss,
                              input logic [15:0] dd, input logic [15:0] mo, input logic [15:0] yy);
    vec_t v;
    v.cmd = c; v.resp = r; v.strb = s;
    v.hh = hh; v.mm = mm; v.ss = ss; v.dd = dd; v.mo = mo; v.yy = yy;
    vecs.push_back(v);
  endfunction

  function automatic logic [3:0] strobes();
    return {set_time, set_date, pause_toggle, speed_toggle};
  endfunction

  // Drive one byte for exactly one cycle; returns at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    send_byte(CR);
  endtask

  task automatic check_values(input string tag, input vec_t v);
    check({tag, " hours"},   {24'd0, hours_bcd},   {24'd0, v.hh});
    check({tag, " minutes"}, {24'd0, minutes_bcd}, {24'd0, v.mm});
    check({tag, " seconds"}, {24'd0, seconds_bcd}, {24'd0, v.ss});
    check({tag, " day"},     {16'd0, day},         {16'd0, v.dd});
    check({tag, " month"},   {16'd0, month},       {16'd0, v.mo});
    check({tag, " year"},    {16'd0, year},        {16'd0, v.yy});
  endtask

  initial begin
    vec_t zero;
    zero.cmd = ""; zero.resp = 8'h00; zero.strb = 4'd0;
    zero.hh = 8'h00; zero.mm = 8'h00; zero.ss = 8'h00;
    zero.dd = 16'd0; zero.mo = 16'd0; zero.yy = 16'd0;

    //    command        resp strobe   hh     mm     ss     day     month   year
    add("T183005",       K, 4'b1000, 8'h18, 8'h30, 8'h05, 16'd0,  16'd0,  16'd0);
    add("D30072024",     K, 4'b0100, 8'h18, 8'h30, 8'h05, 16'd30, 16'd7,  16'd2024);
    add("D32012024",     E, 4'b0000, 8'h18, 8'h30, 8'h05, 16'd30, 16'd7,  16'd2024);
    add("T2400",         E, 4'b0000, 8'h18, 8'h30, 8'h05, 16'd30, 16'd7,  16'd2024);
    add("T12A000",       E, 4'b0000, 8'h18, 8'h30, 8'h05, 16'd30, 16'd7,  16'd2024);
    add("T1200001",      E, 4'b0000, 8'h18, 8'h30, 8'h05, 16'd30, 16'd7,  16'd2024);
    add("X",             E, 4'b0000, 8'h18, 8'h30, 8'h05, 16'd30, 16'd7,  16'd2024);
    add("T000000",       K, 4'b1000, 8'h00, 8'h00, 8'h00, 16'd30, 16'd7,  16'd2024);
    add("T240000",       E, 4'b0000, 8'h00, 8'h00, 8'h00, 16'd30, 16'd7,  16'd2024);
    add("T235959",       K, 4'b1000, 8'h23, 8'h59, 8'h59, 16'd30, 16'd7,  16'd2024);
    add("D00012024",     E, 4'b0000, 8'h23, 8'h59, 8'h59, 16'd30, 16'd7,  16'd2024);
    add("D31129999",     K, 4'b0100, 8'h23, 8'h59, 8'h59, 16'd31, 16'd12, 16'd9999);
    add("D01130000",     E, 4'b0000, 8'h23, 8'h59, 8'h59, 16'd31, 16'd12, 16'd9999);
    add("T000060",       E, 4'b0000, 8'h23, 8'h59, 8'h59, 16'd31, 16'd12, 16'd9999);
    add("D01010000",     K, 4'b0100, 8'h23, 8'h59, 8'h59, 16'd1,  16'd1,  16'd0);
    add("P",             K, 4'b0010, 8'h23, 8'h59, 8'h59, 16'd1,  16'd1,  16'd0);
    add("F",             K, 4'b0001, 8'h23, 8'h59, 8'h59, 16'd1,  16'd1,  16'd0);
    add("P1",            E, 4'b0000, 8'h23, 8'h59, 8'h59, 16'd1,  16'd1,  16'd0);
    add("T00000",        E, 4'b0000, 8'h23, 8'h59, 8'h59, 16'd1,  16'd1,  16'd0);
    add("D0107",         E, 4'b0000, 8'h23, 8'h59, 8'h59, 16'd1,  16'd1,  16'd0);
    add("D1A",           E, 4'b0000, 8'h23, 8'h59, 8'h59, 16'd1,  16'd1,  16'd0);
    add("t183005",       E, 4'b0000, 8'h23, 8'h59, 8'h59, 16'd1,  16'd1,  16'd0);

    rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    #12;
    check("reset tx_valid", {31'd0, tx_valid}, 32'd0);
    check("reset tx_data",  {24'd0, tx_data},  32'd0);
    check("reset strobes",  {28'd0, strobes()}, 32'd0);
    check_values("reset", zero);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[n]) begin
      send_cmd(vecs[n].cmd);
      check({vecs[n].cmd, " tx_valid"}, {31'd0, tx_valid}, 32'd1);
      check({vecs[n].cmd, " tx_data"},  {24'd0, tx_data},  {24'd0, vecs[n].resp});
      check({vecs[n].cmd, " strobes"},  {28'd0, strobes()}, {28'd0, vecs[n].strb});
      check_values(vecs[n].cmd, vecs[n]);
      @(posedge clk); #1;
      check({vecs[n].cmd, " strobe width"}, {28'd0, strobes()}, 32'd0);
      check({vecs[n].cmd, " tx_valid drop"}, {31'd0, tx_valid}, 32'd0);
    end

    // Lone LF and lone CR in IDLE produce nothing, and parsing still works after them.
    send_byte(LF);
    send_byte(CR);
    for (int i = 0; i < 3; i++) begin
      check("idle LF/CR tx_valid", {31'd0, tx_valid}, 32'd0);
      @(posedge clk); #1;
    end
    send_cmd("P");
    check("after LF/CR resp", {24'd0, tx_data}, {24'd0, K});
    check("after LF/CR pause", {31'd0, pause_toggle}, 32'd1);
    @(posedge clk); #1;

    // Held response with tx_ready low; bytes during RESP are dropped.
    tx_ready = 1'b0;
    send_cmd("P");
    for (int i = 0; i < 5; i++) begin
      check("held tx_valid", {31'd0, tx_valid}, 32'd1);
      check("held tx_data", {24'd0, tx_data}, {24'd0, K});
      check("held pause", {31'd0, pause_toggle}, (i == 0) ? 32'd1 : 32'd0);
      check("held speed", {31'd0, speed_toggle}, 32'd0);
      rx_valid = (i < 2);
      rx_data  = (i == 0) ? 8'h46 : CR;
      if (i == 4) tx_ready = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      check("post-held tx_valid", {31'd0, tx_valid}, 32'd0);
      check("post-held speed", {31'd0, speed_toggle}, 32'd0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a time command.
    send_byte(8'h54); send_byte(8'h31); send_byte(8'h38); send_byte(8'h33); send_byte(8'h30);
    rst = 1'b0;
    #2;
    check("midcmd reset tx_valid", {31'd0, tx_valid}, 32'd0);
    check("midcmd reset strobes", {28'd0, strobes()}, 32'd0);
    check_values("midcmd reset", zero);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send_cmd("05");
    check("post-reset 05 tx_valid", {31'd0, tx_valid}, 32'd1);
    check("post-reset 05 tx_data", {24'd0, tx_data}, {24'd0, E});
    check("post-reset 05 strobes", {28'd0, strobes()}, 32'd0);
    check_values("post-reset 05", zero);
    @(posedge clk); #1;

    // Reset while a response is pending.
    tx_ready = 1'b0;
    send_cmd("F");
    check("pending tx_valid", {31'd0, tx_valid}, 32'd1);
    rst = 1'b0;
    #2;
    check("resp reset tx_valid", {31'd0, tx_valid}, 32'd0);
    check("resp reset tx_data", {24'd0, tx_data}, 32'd0);
    check("resp reset speed", {31'd0, speed_toggle}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("resp reset lost", {31'd0, tx_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
